distortion_stage: RTL

Parametrised multi-mode, multi-channel distortion stage with a valid/ready streaming interface, sitting between the I2S receive path and the I2S transmit path of the audio chain. Each signed sample passes through a saturating pre-gain, then one of four shaping modes: bypass, symmetric hard clip, asymmetric clip, or bit-crush. The block handles time-multiplexed channels with a channel tag, and updates its configuration only at frame boundaries. A saturating clip-event counter gives software a distortion-activity metric.

---
 rtl/distortion_stage.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/distortion_stage.sv
// Multi-mode, multi-channel distortion stage on a valid/ready stream.
// Three stages (capture, pre-gain, shaping) move together on advance.
// Config is latched on channel-0 beats so a frame never mixes settings.
module distortion_stage #(
    parameter int DATA_WIDTH = 24,
    parameter int CHANNELS   = 2,
    parameter int GAIN_WIDTH = 8,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            cfg_mode,
    input  logic [GAIN_WIDTH-1:0] cfg_gain,
    input  logic [DATA_WIDTH-2:0] cfg_threshold,
    input  logic [4:0]            cfg_crush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [CH_W-1:0]       s_chan,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CH_W-1:0]       m_chan,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  clip_clr,
    output logic [15:0]           clip_count
);
    localparam int STAGES = 2;
    localparam int PW     = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic signed [PW-1:0] MAXV = {{(GAIN_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    typedef struct packed {
        logic [1:0]            mode;
        logic [GAIN_WIDTH-1:0] gain;
        logic [DATA_WIDTH-2:0] thr;
        logic [4:0]            crush;
    } cfg_t;

    localparam cfg_t CFG_RST = '{mode: 2'd0, gain: GAIN_WIDTH'(16),
                                 thr: {(DATA_WIDTH-1){1'b1}}, crush: 5'd0};

    logic [STAGES:0]              r_vld_pipe;
    cfg_t                         r_act;
    cfg_t                         w_cfg_in, w_beat_cfg;
    logic                         w_adv, w_accept;

    logic signed [DATA_WIDTH-1:0] r_s0_data;
    logic [CH_W-1:0]              r_s0_chan;
    cfg_t                         r_s0_cfg;

    logic signed [PW-1:0]         w_a, w_g, w_prod, w_shr;
    logic signed [DATA_WIDTH-1:0] w_gained;
    logic                         w_sat;

    logic signed [DATA_WIDTH-1:0] r_s1_x;
    logic                         r_s1_sat;
    logic [CH_W-1:0]              r_s1_chan;
    logic [1:0]                   r_s1_mode;
    logic [DATA_WIDTH-2:0]        r_s1_thr;
    logic [4:0]                   r_s1_crush;

    logic signed [DATA_WIDTH-1:0] w_t, w_neg_t, w_neg_half, w_shaped;
    logic [DATA_WIDTH-1:0]        w_mask;
    int                           w_crush_amt;
    logic                         w_evt;

    logic [DATA_WIDTH-1:0]        r_m_data;
    logic [CH_W-1:0]              r_m_chan;
    logic                         r_m_evt;
    logic [15:0]                  r_clip_cnt;

    // Whole pipe stalls only when the output holds an untaken beat
    assign w_adv    = !r_vld_pipe[STAGES] || m_ready;
    assign w_accept = s_valid && w_adv;
    assign s_ready  = w_adv;
    assign m_valid  = r_vld_pipe[STAGES];
    assign m_data   = r_m_data;
    assign m_chan   = r_m_chan;
    assign clip_count = r_clip_cnt;

    // A channel-0 beat picks up the live config for itself and its frame
    assign w_cfg_in   = '{mode: cfg_mode, gain: cfg_gain, thr: cfg_threshold, crush: cfg_crush};
    assign w_beat_cfg = (s_chan == '0) ? w_cfg_in : r_act;

    // Active config register, updated only on accepted channel-0 beats
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                      r_act <= CFG_RST;
        else if (w_accept && s_chan == '0) r_act <= w_cfg_in;
    end

    // Stage valids shift together; bubbles stay in place while stalled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)    r_vld_pipe <= '0;
        else if (w_adv) r_vld_pipe <= {r_vld_pipe[STAGES-1:0], s_valid};
    end

    // S0: capture sample, channel and the config that governs it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s0_data <= '0;
            r_s0_chan <= '0;
            r_s0_cfg  <= CFG_RST;
        end else if (w_accept) begin
            r_s0_data <= s_data;
            r_s0_chan <= s_chan;
            r_s0_cfg  <= w_beat_cfg;
        end
    end

    // Q.4 gain: sign-extend sample, zero-extend gain, full-width product
    assign w_a    = PW'(r_s0_data);
    assign w_g    = PW'({1'b0, r_s0_cfg.gain});
    assign w_prod = w_a * w_g;
    assign w_shr  = w_prod >>> 4;

    // Saturate the scaled value; bypass mode skips gain entirely
    always_comb begin
        w_gained = w_shr[DATA_WIDTH-1:0];
        w_sat    = 1'b0;
        if (r_s0_cfg.mode == 2'd0) begin
            w_gained = r_s0_data;
        end else if (w_shr > MAXV) begin
            w_gained = MAXV[DATA_WIDTH-1:0];
            w_sat    = 1'b1;
        end else if (w_shr < MINV) begin
            w_gained = MINV[DATA_WIDTH-1:0];
            w_sat    = 1'b1;
        end
    end

    // S1: gained sample plus the fields shaping still needs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1_x     <= '0;
            r_s1_sat   <= 1'b0;
            r_s1_chan  <= '0;
            r_s1_mode  <= '0;
            r_s1_thr   <= '0;
            r_s1_crush <= '0;
        end else if (w_adv && r_vld_pipe[0]) begin
            r_s1_x     <= w_gained;
            r_s1_sat   <= w_sat;
            r_s1_chan  <= r_s0_chan;
            r_s1_mode  <= r_s0_cfg.mode;
            r_s1_thr   <= r_s0_cfg.thr;
            r_s1_crush <= r_s0_cfg.crush;
        end
    end

    assign w_t         = {1'b0, r_s1_thr};
    assign w_neg_t     = -w_t;
    assign w_neg_half  = -(w_t >>> 1);
    assign w_crush_amt = (int'(r_s1_crush) > DATA_WIDTH - 1) ? DATA_WIDTH - 1 : int'(r_s1_crush);
    assign w_mask      = {DATA_WIDTH{1'b1}} << w_crush_amt;

    // Shaping; clipping in modes 1/2 or gain saturation marks an event
    always_comb begin
        w_shaped = r_s1_x;
        case (r_s1_mode)
            2'd1: begin
                if (r_s1_x > w_t)           w_shaped = w_t;
                else if (r_s1_x < w_neg_t)  w_shaped = w_neg_t;
            end
            2'd2: begin
                if (r_s1_x > w_t)              w_shaped = w_t;
                else if (r_s1_x < w_neg_half)  w_shaped = w_neg_half;
            end
            2'd3:    w_shaped = r_s1_x & w_mask;
            default: w_shaped = r_s1_x;
        endcase
        w_evt = r_s1_sat || ((r_s1_mode == 2'd1 || r_s1_mode == 2'd2) && (w_shaped != r_s1_x));
    end

    // S2: registered output beat with its event flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m_data <= '0;
            r_m_chan <= '0;
            r_m_evt  <= 1'b0;
        end else if (w_adv && r_vld_pipe[1]) begin
            r_m_data <= w_shaped;
            r_m_chan <= r_s1_chan;
            r_m_evt  <= w_evt;
        end
    end

    // Count events as beats leave; clear wins over a same-cycle event
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_clip_cnt <= '0;
        else if (clip_clr)
            r_clip_cnt <= '0;
        else if (r_vld_pipe[STAGES] && m_ready && r_m_evt && r_clip_cnt != 16'hFFFF)
            r_clip_cnt <= r_clip_cnt + 16'd1;
    end
endmodule
